// File: rtl/ahb_bm_input_stage.sv
// ahb_bm_input_stage
// Bus-matrix slave-port input stage, one instance per master.
// - Passes the master's address phase straight to the matrix when the
//   matrix accepts it in the same cycle (zero added latency).
// - Otherwise captures the address phase into a held register, stalls the
//   master with HREADYOUTS=0, and keeps presenting the held copy until the
//   matrix accepts it.
// - Returns HREADYOUTS/HRESPS from the data-phase target while a data phase
//   from this master is outstanding.
// Build option: define AHB_BM_IS_LOCK_EN to add HMASTLOCKS/HMASTLOCKM; the
// lock bit is then captured and replayed with the address.

module ahb_bm_input_stage #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  // master side
  input  logic                  HSELS,
  input  logic [ADDR_WIDTH-1:0] HADDRS,
  input  logic [1:0]            HTRANSS,
  input  logic                  HWRITES,
  input  logic [2:0]            HSIZES,
  input  logic [2:0]            HBURSTS,
  input  logic [3:0]            HPROTS,
  input  logic                  HREADYS,
`ifdef AHB_BM_IS_LOCK_EN
  input  logic                  HMASTLOCKS,
  output logic                  HMASTLOCKM,
`endif
  output logic                  HREADYOUTS,
  output logic [1:0]            HRESPS,
  // matrix side
  output logic [ADDR_WIDTH-1:0] HADDRM,
  output logic [1:0]            HTRANSM,
  output logic                  HWRITEM,
  output logic [2:0]            HSIZEM,
  output logic [2:0]            HBURSTM,
  output logic [3:0]            HPROTM,
  input  logic                  ACCEPT,
  input  logic                  DP_READY,
  input  logic [1:0]            DP_RESP
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;
  localparam logic [2:0] BURST_INCR   = 3'b001;
  localparam logic [1:0] RESP_OKAY    = 2'b00;

  // One address phase: everything the matrix needs to route a transfer.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] haddr;
    logic [1:0]            htrans;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [2:0]            hburst;
    logic [3:0]            hprot;
`ifdef AHB_BM_IS_LOCK_EN
    logic                  hlock;
`endif
  } aphase_t;

  logic    pend_q, pend_d;
  logic    dp_act_q, dp_act_d;
  aphase_t held_q, held_d;
  aphase_t live_ph;
  aphase_t capt_ph;
  aphase_t pres_ph;
  logic    new_tran;

  assign new_tran = HSELS & HREADYS & HTRANSS[1];

  // Live address phase as seen on the master port; zero while unselected so
  // an idle port drives a quiet address bus into the matrix.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    live_ph        = '0;
    live_ph.htrans = (HSELS & HREADYS) ? HTRANSS : TRANS_IDLE;
    if (HSELS) begin
      live_ph.haddr  = HADDRS;
      live_ph.hwrite = HWRITES;
      live_ph.hsize  = HSIZES;
      live_ph.hburst = HBURSTS;
      live_ph.hprot  = HPROTS;
`ifdef AHB_BM_IS_LOCK_EN
      live_ph.hlock  = HMASTLOCKS;
`endif
    end
  end

  // Form the copy to hold: a held SEQ loses its burst context once it is
  // detached from its predecessor, so it is replayed as an INCR NONSEQ.
  always_comb begin
    capt_ph = live_ph;
    if (live_ph.htrans == TRANS_SEQ) begin
      capt_ph.htrans = TRANS_NONSEQ;
      capt_ph.hburst = BURST_INCR;
    end
  end

  // Select the phase presented to the matrix: held copy wins while pending.
  always_comb begin
    pres_ph = pend_q ? held_q : live_ph;
  end

  // Next-state for the pending flag, held copy and data-phase tracker.
  always_comb begin
    pend_d   = pend_q;
    held_d   = held_q;
    dp_act_d = dp_act_q;

    if (pend_q) begin
      // Master is stalled, live inputs are ignored until the matrix takes it.
      if (ACCEPT) begin
        pend_d = 1'b0;
      end
    end else if (new_tran && !ACCEPT) begin
      pend_d = 1'b1;
      held_d = capt_ph;
    end

    if (ACCEPT && pres_ph.htrans[1]) begin
      dp_act_d = 1'b1;
    end else if (DP_READY) begin
      dp_act_d = 1'b0;
    end
  end

  // State registers; the held copy is reset too so HTRANSM reads IDLE.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      pend_q   <= 1'b0;
      dp_act_q <= 1'b0;
      held_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      pend_q   <= pend_d;
      dp_act_q <= dp_act_d;
      held_q   <= held_d;
    end
  end

  // Drive the matrix-side address phase and the master-side response.
  always_comb begin
    HADDRM     = pres_ph.haddr;
    HTRANSM    = pres_ph.htrans;
    HWRITEM    = pres_ph.hwrite;
    HSIZEM     = pres_ph.hsize;
    HBURSTM    = pres_ph.hburst;
    HPROTM     = pres_ph.hprot;
`ifdef AHB_BM_IS_LOCK_EN
    HMASTLOCKM = pres_ph.hlock;
`endif
    HREADYOUTS = pend_q ? 1'b0 : (dp_act_q ? DP_READY : 1'b1);
    HRESPS     = dp_act_q ? DP_RESP : RESP_OKAY;
  end

endmodule

// File: tb/tb_ahb_bm_input_stage.sv
// tb_ahb_bm_input_stage
// Directed vectors with hand-computed expected outputs. The stimulus process
// drives one vector per cycle and queues its expected outputs; a monitor
// pops and compares the DUT outputs on the falling edge of that cycle.
// Lock checks are active when AHB_BM_IS_LOCK_EN is defined.

module tb_ahb_bm_input_stage;

  localparam int AW = 32;
  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NS = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000, INCR = 3'b001, INCR4 = 3'b011;

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b1;
  logic          HSELS = 1'b0;
  logic [AW-1:0] HADDRS = '0;
  logic [1:0]    HTRANSS = IDLE;
  logic          HWRITES = 1'b0;
  logic [2:0]    HSIZES = 3'd2;
  logic [2:0]    HBURSTS = SINGLE;
  logic [3:0]    HPROTS = 4'h3;
  logic          HREADYS = 1'b1;
  logic          HREADYOUTS;
  logic [1:0]    HRESPS;
  logic [AW-1:0] HADDRM;
  logic [1:0]    HTRANSM;
  logic          HWRITEM;
  logic [2:0]    HSIZEM;
  logic [2:0]    HBURSTM;
  logic [3:0]    HPROTM;
  logic          ACCEPT = 1'b0;
  logic          DP_READY = 1'b1;
  logic [1:0]    DP_RESP = 2'b00;
  logic          HMASTLOCKS = 1'b0;
  logic          HMASTLOCKM;

  always #5 HCLK = ~HCLK;

  ahb_bm_input_stage #(.ADDR_WIDTH(AW)) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .HSELS      (HSELS),
    .HADDRS     (HADDRS),
    .HTRANSS    (HTRANSS),
    .HWRITES    (HWRITES),
    .HSIZES     (HSIZES),
    .HBURSTS    (HBURSTS),
    .HPROTS     (HPROTS),
    .HREADYS    (HREADYS),
`ifdef AHB_BM_IS_LOCK_EN
    .HMASTLOCKS (HMASTLOCKS),
    .HMASTLOCKM (HMASTLOCKM),
`endif
    .HREADYOUTS (HREADYOUTS),
    .HRESPS     (HRESPS),
    .HADDRM     (HADDRM),
    .HTRANSM    (HTRANSM),
    .HWRITEM    (HWRITEM),
    .HSIZEM     (HSIZEM),
    .HBURSTM    (HBURSTM),
    .HPROTM     (HPROTM),
    .ACCEPT     (ACCEPT),
    .DP_READY   (DP_READY),
    .DP_RESP    (DP_RESP)
  );

`ifndef AHB_BM_IS_LOCK_EN
  assign HMASTLOCKM = 1'b0;
`endif

  typedef struct {
    string         name;
    logic          rdy;
    logic [1:0]    resp;
    logic [1:0]    trans;
    logic [AW-1:0] addr;
    logic          write;
    logic [2:0]    burst;
    logic [2:0]    size;
    logic [3:0]    prot;
    logic          lock;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic ok, input string act, input string req);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %s, expected %s", name, act, req);
    end
  endtask

  // Monitor: compare the DUT outputs against the oldest queued expectation.
  always @(negedge HCLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic ok;
      e  = exp_q.pop_front();
      ok = (HREADYOUTS === e.rdy) && (HRESPS === e.resp) && (HTRANSM === e.trans) &&
           (HADDRM === e.addr) && (HWRITEM === e.write) && (HBURSTM === e.burst) &&
           (HSIZEM === e.size) && (HPROTM === e.prot);
`ifdef AHB_BM_IS_LOCK_EN
      ok = ok && (HMASTLOCKM === e.lock);
`endif
      check(e.name, ok,
        $sformatf("rdy=%b resp=%b trans=%b addr=%h wr=%b burst=%b size=%0d prot=%h lock=%b",
                  HREADYOUTS, HRESPS, HTRANSM, HADDRM, HWRITEM, HBURSTM, HSIZEM, HPROTM, HMASTLOCKM),
        $sformatf("rdy=%b resp=%b trans=%b addr=%h wr=%b burst=%b size=%0d prot=%h lock=%b",
                  e.rdy, e.resp, e.trans, e.addr, e.write, e.burst, e.size, e.prot, e.lock));
    end
  end

  // Apply one vector just after the rising edge and queue its expectation.
  // e_on: address outputs are active, so size/prot read back as 2/3.
  task automatic step(
    input string name,
    input logic rst, input logic hsel, input logic [AW-1:0] addr, input logic [1:0] trans,
    input logic write, input logic [2:0] burst, input logic hready, input logic accept,
    input logic dpr, input logic [1:0] dpresp, input logic lock,
    input logic e_rdy, input logic [1:0] e_resp, input logic [1:0] e_trans,
    input logic [AW-1:0] e_addr, input logic e_write, input logic [2:0] e_burst,
    input logic e_on, input logic e_lock);
    exp_t e;
    @(posedge HCLK);
    #1;
    HRESET = rst; HSELS = hsel; HADDRS = addr; HTRANSS = trans; HWRITES = write;
    HBURSTS = burst; HREADYS = hready; ACCEPT = accept; DP_READY = dpr;
    DP_RESP = dpresp; HMASTLOCKS = lock;
    HSIZES = 3'd2; HPROTS = 4'h3;
    e.name = name; e.rdy = e_rdy; e.resp = e_resp; e.trans = e_trans; e.addr = e_addr;
    e.write = e_write; e.burst = e_burst;
    e.size = e_on ? 3'd2 : 3'd0;
    e.prot = e_on ? 4'h3 : 4'h0;
`ifdef AHB_BM_IS_LOCK_EN
    e.lock = e_lock;
`else
    e.lock = 1'b0;
`endif
    exp_q.push_back(e);
  endtask

  initial begin
    //   name          rst sel addr          trans wr burst hrdy acc dpr resp lk | rdy resp trans addr          wr burst on lk
    step("reset",       1, 0, 32'h0,         IDLE, 0, SINGLE, 1, 0, 1, 2'b00, 0,  1, 2'b00, IDLE, 32'h0,         0, SINGLE, 0, 0);
    step("ns_wr_acc",   0, 1, 32'h2000_0000, NS,   1, SINGLE, 1, 1, 1, 2'b00, 0,  1, 2'b00, NS,   32'h2000_0000, 1, SINGLE, 1, 0);
    step("ns_rd_issue", 0, 1, 32'h4000_0010, NS,   0, INCR4,  1, 0, 1, 2'b00, 1,  1, 2'b00, NS,   32'h4000_0010, 0, INCR4,  1, 1);
    step("stall_1",     0, 1, 32'hDEAD_BEEF, NS,   1, SINGLE, 0, 0, 1, 2'b00, 0,  0, 2'b00, NS,   32'h4000_0010, 0, INCR4,  1, 1);
    step("stall_2",     0, 1, 32'hDEAD_BEEF, NS,   1, SINGLE, 0, 0, 1, 2'b00, 0,  0, 2'b00, NS,   32'h4000_0010, 0, INCR4,  1, 1);
    step("replay_acc",  0, 1, 32'hDEAD_BEEF, NS,   1, SINGLE, 0, 1, 1, 2'b00, 0,  0, 2'b00, NS,   32'h4000_0010, 0, INCR4,  1, 1);
    step("seq_issue",   0, 1, 32'h4000_0014, SEQ,  0, INCR4,  1, 0, 1, 2'b00, 0,  1, 2'b00, SEQ,  32'h4000_0014, 0, INCR4,  1, 0);
    step("seq_replay",  0, 0, 32'h0,         IDLE, 0, SINGLE, 0, 1, 1, 2'b00, 0,  0, 2'b00, NS,   32'h4000_0014, 0, INCR,   1, 0);
    step("err_cycle1",  0, 0, 32'h0,         IDLE, 0, SINGLE, 0, 0, 0, 2'b01, 0,  0, 2'b01, IDLE, 32'h0,         0, SINGLE, 0, 0);
    step("err_cycle2",  0, 0, 32'h0,         IDLE, 0, SINGLE, 1, 0, 1, 2'b01, 0,  1, 2'b01, IDLE, 32'h0,         0, SINGLE, 0, 0);
    step("idle_acc",    0, 1, 32'h1234_0000, IDLE, 0, SINGLE, 1, 1, 1, 2'b00, 0,  1, 2'b00, IDLE, 32'h1234_0000, 0, SINGLE, 1, 0);
    step("busy_acc",    0, 1, 32'h1234_0004, BUSY, 0, SINGLE, 1, 1, 1, 2'b00, 0,  1, 2'b00, BUSY, 32'h1234_0004, 0, SINGLE, 1, 0);
    step("no_dp_after", 0, 0, 32'h0,         IDLE, 0, SINGLE, 1, 0, 0, 2'b01, 0,  1, 2'b00, IDLE, 32'h0,         0, SINGLE, 0, 0);
    step("wr_acc_2",    0, 1, 32'h8000_0000, NS,   1, SINGLE, 1, 1, 1, 2'b00, 0,  1, 2'b00, NS,   32'h8000_0000, 1, SINGLE, 1, 0);
    step("wr_stall_dp", 0, 1, 32'h8000_0004, NS,   1, SINGLE, 1, 0, 0, 2'b00, 0,  0, 2'b00, NS,   32'h8000_0004, 1, SINGLE, 1, 0);
    step("pend_and_dp", 0, 0, 32'h0,         IDLE, 0, SINGLE, 0, 0, 0, 2'b01, 0,  0, 2'b01, NS,   32'h8000_0004, 1, SINGLE, 1, 0);
    step("mid_reset",   1, 0, 32'h0,         IDLE, 0, SINGLE, 0, 0, 0, 2'b01, 0,  1, 2'b00, IDLE, 32'h0,         0, SINGLE, 0, 0);
    step("post_reset",  0, 0, 32'h0,         IDLE, 0, SINGLE, 0, 0, 0, 2'b01, 0,  1, 2'b00, IDLE, 32'h0,         0, SINGLE, 0, 0);

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge HCLK);
    check("drain", exp_q.size() == 0, $sformatf("%0d pending", exp_q.size()), "0 pending");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
